mips_mc_control: RTL and testbench
==================================

Name: mips_mc_control

Overview:
- Moore main-control FSM for the multi-cycle MIPS core.
- Sequences one instruction through fetch, decode, execute, memory and writeback states.
- Drives datapath muxes, register/memory enables and the 2-bit ALU op class into the Execute-stage ALU control decoder.
- Stalls on a memory-ready handshake.

Parameters:
- WAIT_ON_MEM, 1: if 1, FETCH/MEMRD/MEMWR hold until mem_ready; if 0, mem_ready is ignored (single-cycle memory).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  instr[31:26] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- pc_en  out  1  PC load enable = pc_write | (branch & zero)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- reg_dst  out  1  write register select: 1 = rd, 0 = rt
- mem_to_reg  out  1  writeback source: 1 = MDR, 0 = ALUOut
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A: 0 = PC, 1 = A register
- alu_src_b  out  2  ALU B: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- alu_op  out  2  00 = add, 01 = sub, 10 = R-type funct decode
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  out  1  one-cycle pulse, in DECODE, for an unsupported opcode
- state  out  4  current state, for debug

Behaviour:
- State register is clocked on clk rising edge.
- rst asserted, at any time: state = FETCH immediately, asynchronously. Any in-flight instruction is abandoned with no further writes.
- Outputs are pure decodes of state (plus zero/opcode/mem_ready where listed). They are valid in the same cycle as state; there is no output register.
- Every output not listed as active in a state is 0.
- Outputs in reset/FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; all others 0.
- States (4-bit codes):
  - FETCH=0
  - DECODE=1
  - MEMADR=2
  - MEMRD=3
  - MEMWB=4
  - MEMWR=5
  - EXEC=6
  - ALUWB=7
  - BRANCH=8
  - ADDIEX=9
  - ADDIWB=10
  - JUMP=11
- FETCH:
  - ir_write = mem_ready, pc_write = mem_ready (PC+4).
  - Next state = DECODE when mem_ready (or always when WAIT_ON_MEM=0), else FETCH.
  - Neither PC nor IR changes while stalled.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode:
    - 100011 (lw) / 101011 (sw) -> MEMADR
    - 000000 -> EXEC
    - 000100 -> BRANCH
    - 001000 -> ADDIEX
    - 000010 -> JUMP
    - any other opcode -> FETCH, with illegal_op=1
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1, mem_read=1. Next state MEMWB on mem_ready, else hold.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next state FETCH.
- MEMWR: iord=1, mem_write=1. Next state FETCH on mem_ready, else hold. mem_write stays high for the whole stall.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next state ALUWB.
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1, so pc_en=zero. Next state FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next state ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Next state FETCH.
- JUMP: pc_src=10, pc_write=1. Next state FETCH.
- Instruction cycle counts, with mem_ready=1:
  - lw = 5
  - sw, R-type, addi = 4
  - beq, j = 3
  - illegal opcode = 2
- Unused state codes 12-15 -> FETCH next cycle; all outputs 0 while in them.
- mem_ready is sampled only in FETCH/MEMRD/MEMWR and ignored in every other state.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - ALUOp constants: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10
  - state encodings
- These are shared with the ALU control decoder and the top-level datapath.
- One natural sub-module: mips_mc_outdec, the combinational state -> control-word decoder. The FSM keeps only the next-state logic and the state register.

Test Plan:
1. Assert rst mid-MEMRD -> state=0 with no clock edge; mem_read=1, iord=0, alu_src_b=01, reg_write=0.
2. lw (opcode 100011), mem_ready held 1 -> state sequence 0,1,2,3,4,0. reg_write=1 only in state 4, with mem_to_reg=1 and reg_dst=0.
3. R-type, funct 100010 -> alu_op=10 in EXEC; ALUWB has reg_dst=1, reg_write=1. Total 4 cycles.
4. beq with zero=1, then with zero=0 -> in BRANCH, pc_en=1 with pc_src=01 for the first and pc_en=0 for the second; alu_op=01 in both.
5. sw with mem_ready low for 3 cycles in MEMWR -> state stays 5 and mem_write=1 for 4 cycles, then state 0. FETCH stalls the same way, with ir_write=0 until mem_ready.
6. Opcode 111111 -> DECODE pulses illegal_op=1, then FETCH; no reg_write or mem_write at any point. With WAIT_ON_MEM=0, mem_ready=0 still completes a 5-cycle lw.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared opcode, ALUOp, mux-select and state encodings for the multi-cycle MIPS core.
// Used by the main control FSM, the ALU control decoder and the datapath top.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_J) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_mc_outdec.sv
// Combinational state -> control-word decode for the multi-cycle control FSM; zero latency.
// No backpressure of its own: FETCH only commits PC/IR when memory is ready.
module mips_mc_outdec
  import mips_pkg::*;
#(
  parameter int WAIT_ON_MEM = 1
) (
  input  logic [3:0] state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl,
  output logic       illegal_op
);

  logic mem_go;
  assign mem_go = mem_ready || (WAIT_ON_MEM == 0);

  always_comb begin
    ctrl       = '0;
    illegal_op = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        // PC+4 and IR load only on the cycle the fetch actually completes
        ctrl.ir_write  = mem_go;
        ctrl.pc_write  = mem_go;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
        illegal_op     = !op_legal(opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Moore main-control FSM for the multi-cycle MIPS core; outputs decode the current state, no register.
// Stalls in FETCH/MEMRD/MEMWR until mem_ready (unless WAIT_ON_MEM=0).
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int WAIT_ON_MEM = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic [3:0] state
);

  logic [3:0] state_q;
  logic [3:0] state_nxt;
  logic       mem_go;
  ctrl_t      ctrl;

  assign mem_go = mem_ready || (WAIT_ON_MEM == 0);

  always_comb begin
    state_nxt = S_FETCH;
    case (state_q)
      S_FETCH:  state_nxt = mem_go ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR: state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nxt = mem_go ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_nxt = mem_go ? S_FETCH : S_MEMWR;
      S_EXEC:   state_nxt = S_ALUWB;
      S_ADDIEX: state_nxt = S_ADDIWB;
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_nxt;
  end

  mips_mc_outdec #(
    .WAIT_ON_MEM(WAIT_ON_MEM)
  ) u_outdec (
    .state      (state_q),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .ctrl       (ctrl),
    .illegal_op (illegal_op)
  );

  assign pc_en      = ctrl.pc_write | (ctrl.branch & zero);
  assign iord       = ctrl.iord;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_src     = ctrl.pc_src;
  assign state      = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: one instance with memory wait, one with WAIT_ON_MEM=0.
module tb_mips_mc_control;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

  // {pc_en,iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,alu_op,pc_src,illegal_op}
  localparam logic [15:0] W_FETCH       = 16'b1_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [15:0] W_FETCH_STALL = 16'b0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [15:0] W_DECODE      = 16'b0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [15:0] W_DECODE_ILL  = 16'b0_0_0_0_0_0_0_0_0_11_00_00_1;
  localparam logic [15:0] W_MEMADR      = 16'b0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [15:0] W_MEMRD       = 16'b0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [15:0] W_MEMWB       = 16'b0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [15:0] W_MEMWR       = 16'b0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [15:0] W_EXEC        = 16'b0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [15:0] W_ALUWB       = 16'b0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [15:0] W_BR_T        = 16'b1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [15:0] W_BR_NT       = 16'b0_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [15:0] W_ADDIEX      = 16'b0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [15:0] W_ADDIWB      = 16'b0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [15:0] W_JUMP        = 16'b1_0_0_0_0_0_0_0_0_00_00_10_0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst1, zero, zero1, mem_ready, mem_ready1;
  logic [5:0] opcode, opcode1;

  logic       d0_pc_en, d0_iord, d0_mem_read, d0_mem_write, d0_ir_write, d0_reg_dst;
  logic       d0_mem_to_reg, d0_reg_write, d0_alu_src_a, d0_illegal_op;
  logic [1:0] d0_alu_src_b, d0_alu_op, d0_pc_src;
  logic [3:0] d0_state;
  logic       d1_pc_en, d1_iord, d1_mem_read, d1_mem_write, d1_ir_write, d1_reg_dst;
  logic       d1_mem_to_reg, d1_reg_write, d1_alu_src_a, d1_illegal_op;
  logic [1:0] d1_alu_src_b, d1_alu_op, d1_pc_src;
  logic [3:0] d1_state;

  mips_mc_control #(.WAIT_ON_MEM(1)) dut0 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(d0_pc_en), .iord(d0_iord), .mem_read(d0_mem_read), .mem_write(d0_mem_write),
    .ir_write(d0_ir_write), .reg_dst(d0_reg_dst), .mem_to_reg(d0_mem_to_reg),
    .reg_write(d0_reg_write), .alu_src_a(d0_alu_src_a), .alu_src_b(d0_alu_src_b),
    .alu_op(d0_alu_op), .pc_src(d0_pc_src), .illegal_op(d0_illegal_op), .state(d0_state)
  );

  mips_mc_control #(.WAIT_ON_MEM(0)) dut1 (
    .clk(clk), .rst(rst1), .opcode(opcode1), .zero(zero1), .mem_ready(mem_ready1),
    .pc_en(d1_pc_en), .iord(d1_iord), .mem_read(d1_mem_read), .mem_write(d1_mem_write),
    .ir_write(d1_ir_write), .reg_dst(d1_reg_dst), .mem_to_reg(d1_mem_to_reg),
    .reg_write(d1_reg_write), .alu_src_a(d1_alu_src_a), .alu_src_b(d1_alu_src_b),
    .alu_op(d1_alu_op), .pc_src(d1_pc_src), .illegal_op(d1_illegal_op), .state(d1_state)
  );

  logic [15:0] word0, word1;
  assign word0 = {d0_pc_en, d0_iord, d0_mem_read, d0_mem_write, d0_ir_write, d0_reg_dst,
                  d0_mem_to_reg, d0_reg_write, d0_alu_src_a, d0_alu_src_b, d0_alu_op,
                  d0_pc_src, d0_illegal_op};
  assign word1 = {d1_pc_en, d1_iord, d1_mem_read, d1_mem_write, d1_ir_write, d1_reg_dst,
                  d1_mem_to_reg, d1_reg_write, d1_alu_src_a, d1_alu_src_b, d1_alu_op,
                  d1_pc_src, d1_illegal_op};

  typedef struct {
    bit          chk0;
    logic [3:0]  st0;
    logic [15:0] w0;
    bit          chk1;
    logic [3:0]  st1;
    logic [15:0] w1;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  int   n_step = 0;
  bit   done = 1'b0;

  // Monitor: one expected record per cycle, sampled mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk0) begin
        total++;
        if (d0_state !== e.st0) begin
          bad++;
          $display("FAIL step%0d dut0 state: got %0d want %0d", e.id, d0_state, e.st0);
        end
        total++;
        if (word0 !== e.w0) begin
          bad++;
          $display("FAIL step%0d dut0 ctrl: got %b want %b", e.id, word0, e.w0);
        end
      end
      if (e.chk1) begin
        total++;
        if (d1_state !== e.st1) begin
          bad++;
          $display("FAIL step%0d dut1 state: got %0d want %0d", e.id, d1_state, e.st1);
        end
        total++;
        if (word1 !== e.w1) begin
          bad++;
          $display("FAIL step%0d dut1 ctrl: got %b want %b", e.id, word1, e.w1);
        end
      end
    end else if (done) begin
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  // Drive dut0 for one cycle; dut1 is held in reset and must present FETCH.
  task automatic step(input logic r, input logic [5:0] op, input logic z, input logic mr,
                      input logic [3:0] est, input logic [15:0] ew);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; opcode = op; zero = z; mem_ready = mr;
    x.chk0 = 1'b1; x.st0 = est; x.w0 = ew;
    x.chk1 = 1'b1; x.st1 = 4'd0; x.w1 = W_FETCH;
    x.id = n_step;
    n_step++;
    sb.push_back(x);
  endtask

  task automatic step1(input logic r1, input logic [3:0] est, input logic [15:0] ew);
    exp_t x;
    @(posedge clk);
    #1;
    rst1 = r1;
    x.chk0 = 1'b0; x.st0 = 4'd0; x.w0 = 16'd0;
    x.chk1 = 1'b1; x.st1 = est; x.w1 = ew;
    x.id = n_step;
    n_step++;
    sb.push_back(x);
  endtask

  initial begin
    rst = 1'b1; opcode = RT; zero = 1'b0; mem_ready = 1'b0;
    rst1 = 1'b1; opcode1 = LW; zero1 = 1'b0; mem_ready1 = 1'b0;

    step(1, RT, 0, 0, 4'd0, W_FETCH_STALL);
    // lw: 5 cycles
    step(0, LW, 0, 1, 4'd0, W_FETCH);
    step(0, LW, 0, 1, 4'd1, W_DECODE);
    step(0, LW, 1, 1, 4'd2, W_MEMADR);
    step(0, LW, 0, 1, 4'd3, W_MEMRD);
    step(0, LW, 1, 0, 4'd4, W_MEMWB);
    // R-type: 4 cycles, mem_ready ignored in EXEC
    step(0, RT, 0, 1, 4'd0, W_FETCH);
    step(0, RT, 0, 1, 4'd1, W_DECODE);
    step(0, RT, 1, 0, 4'd6, W_EXEC);
    step(0, RT, 0, 1, 4'd7, W_ALUWB);
    // beq taken / not taken
    step(0, BEQ, 0, 1, 4'd0, W_FETCH);
    step(0, BEQ, 0, 1, 4'd1, W_DECODE);
    step(0, BEQ, 1, 1, 4'd8, W_BR_T);
    step(0, BEQ, 0, 1, 4'd0, W_FETCH);
    step(0, BEQ, 1, 1, 4'd1, W_DECODE);
    step(0, BEQ, 0, 1, 4'd8, W_BR_NT);
    // addi and j
    step(0, ADDI, 0, 1, 4'd0, W_FETCH);
    step(0, ADDI, 0, 1, 4'd1, W_DECODE);
    step(0, ADDI, 0, 1, 4'd9, W_ADDIEX);
    step(0, ADDI, 0, 1, 4'd10, W_ADDIWB);
    step(0, J, 0, 1, 4'd0, W_FETCH);
    step(0, J, 1, 1, 4'd1, W_DECODE);
    step(0, J, 0, 0, 4'd11, W_JUMP);
    // sw with a stalled fetch and a 3-cycle stalled write
    step(0, SW, 0, 0, 4'd0, W_FETCH_STALL);
    step(0, SW, 0, 0, 4'd0, W_FETCH_STALL);
    step(0, SW, 0, 1, 4'd0, W_FETCH);
    step(0, SW, 0, 1, 4'd1, W_DECODE);
    step(0, SW, 0, 0, 4'd2, W_MEMADR);
    step(0, SW, 0, 0, 4'd5, W_MEMWR);
    step(0, SW, 0, 0, 4'd5, W_MEMWR);
    step(0, SW, 0, 0, 4'd5, W_MEMWR);
    step(0, SW, 0, 1, 4'd5, W_MEMWR);
    // illegal opcode: 2 cycles
    step(0, BAD, 0, 1, 4'd0, W_FETCH);
    step(0, BAD, 0, 1, 4'd1, W_DECODE_ILL);
    // lw stalled in MEMRD, then reset lands between clock edges
    step(0, LW, 0, 1, 4'd0, W_FETCH);
    step(0, LW, 0, 1, 4'd1, W_DECODE);
    step(0, LW, 0, 1, 4'd2, W_MEMADR);
    step(0, LW, 0, 0, 4'd3, W_MEMRD);
    step(1, LW, 0, 0, 4'd0, W_FETCH_STALL);
    step(1, LW, 0, 0, 4'd0, W_FETCH_STALL);
    step(0, LW, 0, 1, 4'd0, W_FETCH);
    step(0, LW, 0, 1, 4'd1, W_DECODE);

    // WAIT_ON_MEM=0 instance: lw completes in 5 cycles with mem_ready low
    step1(1, 4'd0, W_FETCH);
    step1(0, 4'd0, W_FETCH);
    step1(0, 4'd1, W_DECODE);
    step1(0, 4'd2, W_MEMADR);
    step1(0, 4'd3, W_MEMRD);
    step1(0, 4'd4, W_MEMWB);
    step1(0, 4'd0, W_FETCH);

    @(posedge clk);
    #1;
    done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL timeout: monitor never drained, got %0d pending want 0", sb.size());
    $fatal(1, "timeout");
  end

endmodule
